// File: rtl/checksum_sched_pkg.sv
// checksum_sched_pkg: shared state encoding, default widths and id-width helper for checksum_scheduler
package checksum_sched_pkg;
  localparam int NUM_REQ_D = 2;
  localparam int ADDR_W_D = 4;
  localparam int DATA_W_D = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/checksum_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant, first valid requester at or after ptr (circular)
module rr_arbiter
  import checksum_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any
);
  logic [2*NUM_REQ-1:0] rot;
  logic [ID_W:0]        idx;
  // rotate the doubled request vector so bit 0 is ptr, pick the lowest set bit, unrotate
  always_comb begin
    rot = {valid, valid} >> ptr;
    idx = {1'b0, ptr};
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) idx = {1'b0, ptr} + (ID_W+1)'(i);
    grant = idx >= (ID_W+1)'(NUM_REQ) ? ID_W'(idx - (ID_W+1)'(NUM_REQ)) : idx[ID_W-1:0];
    any = |valid;
  end
endmodule

// File: rtl/checksum_scheduler.sv
// checksum_scheduler: round-robin range-sum engine over a shared sync-read memory; CHECKSUM_SCHED_OVERFLOW_EN adds rsp_overflow
module checksum_scheduler
  import checksum_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_base,
  input  logic [NUM_REQ*(ADDR_W+1)-1:0] req_len,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_sum,
  output logic                        busy
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
  , output logic                      rsp_overflow
`endif
);
  state_t            state, nxt;
  logic [ID_W-1:0]   rr_ptr, id, grant;
  logic              any, accept, rd_q;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len, cnt, glen;
  logic [DATA_W-1:0] sum, nsum;
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
  logic              ovf, carry;
  assign {carry, nsum} = {1'b0, sum} + {1'b0, mem_rd_data};
  assign rsp_overflow = ovf;
`else
  assign nsum = sum + mem_rd_data;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .any  (any)
  );

  assign accept = (state == IDLE) && any;
  assign glen = req_len[grant*(ADDR_W+1) +: ADDR_W+1];

  // next-state and handshake/memory outputs
  always_comb begin
    nxt = state == IDLE  ? (accept ? (glen != '0 ? ISSUE : RESP) : IDLE) :
          state == ISSUE ? (cnt == len - (ADDR_W+1)'(1) ? DRAIN : ISSUE) :
          state == DRAIN ? RESP :
          (rsp_ready ? IDLE : RESP);
    req_ready = accept ? NUM_REQ'(1) << grant : '0;
    mem_rd_en = state == ISSUE;
    mem_rd_addr = mem_rd_en ? base + cnt[ADDR_W-1:0] : '0;
    rsp_valid = state == RESP;
    rsp_id = id;
    rsp_sum = sum;
    busy = state != IDLE;
  end

  // state, request latch and accumulator; data lands one cycle after each read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      id <= '0;
      base <= '0;
      len <= '0;
      cnt <= '0;
      sum <= '0;
      rd_q <= 1'b0;
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
      ovf <= 1'b0;
`endif
    end else begin
      state <= nxt;
      rd_q <= mem_rd_en;
      if (accept) begin
        base <= req_base[grant*ADDR_W +: ADDR_W];
        len <= glen;
        id <= grant;
        cnt <= '0;
        sum <= '0;
        rr_ptr <= grant == ID_W'(NUM_REQ - 1) ? '0 : grant + ID_W'(1);
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
        ovf <= 1'b0;
`endif
      end else begin
        if (mem_rd_en) cnt <= cnt + (ADDR_W+1)'(1);
        if (rd_q) begin
          sum <= nsum;
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
          ovf <= ovf | carry;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_checksum_scheduler.sv
// tb_checksum_scheduler: scoreboard bench for checksum_scheduler (2 requesters, 16x32 memory)
module tb_checksum_scheduler;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req_base = '0;
  logic [9:0]  req_len = '0;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_sum;
  logic        busy;
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
  logic        rsp_overflow;
`endif

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;
  logic rr = 1'b0;
  logic g;
  logic [32:0] e;
  logic [32:0] exp_q[$];
  logic        exp_id_q[$];
  logic [3:0]  addr_q[$];

  checksum_scheduler #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_len    (req_len),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .busy       (busy)
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
    , .rsp_overflow(rsp_overflow)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] b, input logic [4:0] l);
    logic [32:0] a = '0;
    logic o = 1'b0;
    for (int k = 0; k < int'(l); k++) begin
      a = {1'b0, a[31:0]} + {1'b0, mem[b + 4'(k)]};
      o = o | a[32];
    end
    return {o, a[31:0]};
  endfunction

  // scoreboard: predict grant on accept, compare on response handshake
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_id_q.delete();
      rr = 1'b0;
    end else begin
      if (mem_rd_en) addr_q.push_back(mem_rd_addr);
      if (|req_ready) begin
        g = req_valid[rr] ? rr : ~rr;
        check("grant", req_ready, 2'b1 << g);
        exp_id_q.push_back(g);
        exp_q.push_back(model(req_base[g*4 +: 4], req_len[g*5 +: 5]));
        rr = ~g;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, exp_id_q.pop_front());
          check("rsp_sum", rsp_sum, e[31:0]);
`ifdef CHECKSUM_SCHED_OVERFLOW_EN
          check("rsp_overflow", rsp_overflow, e[32]);
`endif
        end
      end
    end
  end

  task automatic do_req(input int id, input logic [3:0] b, input logic [4:0] l,
                        output int lat, output logic [31:0] s);
    req_base[id*4 +: 4] = b;
    req_len[id*5 +: 5] = l;
    req_valid[id] = 1'b1;
    lat = 0;
    s = '0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (req_ready[id]) break;
    end
    if (!req_ready[id]) begin
      check("accept_timeout", 0, 1);
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    req_valid[id] = 1'b0;
    req_base[id*4 +: 4] = ~b;
    req_len[id*5 +: 5] = 5'd9;
    for (lat = 1; lat < 60; lat++) begin
      @(negedge clock);
      if (rsp_valid) break;
    end
    s = rsp_sum;
    @(posedge clock);
    #1;
  endtask

  int lat;
  logic [31:0] s;
  int cnt;
  int ids[4];
  logic [3:0] wa[4];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = i;
    wa = '{4'd14, 4'd15, 4'd0, 4'd1};
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    addr_q.delete();
    do_req(0, 4'd0, 5'd16, lat, s);
    check("lat_len16", lat, 18);
    check("sum_len16", s, 120);
    check("reads_len16", addr_q.size(), 16);

    addr_q.delete();
    do_req(1, 4'd14, 5'd4, lat, s);
    check("lat_wrap", lat, 6);
    check("sum_wrap", s, 30);
    check("reads_wrap", addr_q.size(), 4);
    for (int i = 0; i < 4; i++) check("addr_wrap", addr_q[i], wa[i]);

    req_base = {4'd5, 4'd3};
    req_len = {5'd1, 5'd1};
    req_valid = 2'b11;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (rsp_valid && rsp_ready) begin
        ids[cnt] = int'(rsp_id);
        cnt++;
        if (cnt == 4) break;
      end
    end
    @(posedge clock);
    #1;
    req_valid = 2'b00;
    check("fair_count", cnt, 4);
    for (int i = 0; i < 4; i++) check("fair_order", ids[i], i % 2);

    rsp_ready = 1'b0;
    req_base = {4'd5, 4'd2};
    req_len = {5'd1, 5'd2};
    req_valid = 2'b01;
    for (int n = 0; n < 50 && !req_ready[0]; n++) @(negedge clock);
    @(posedge clock);
    #1;
    req_valid = 2'b10;
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 0);
      check("bp_rsp_sum", rsp_sum, 5);
      check("bp_req_ready", req_ready, 0);
      check("bp_mem_rd_en", mem_rd_en, 0);
    end
    @(posedge clock);
    #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("bp_done_busy", busy, 0);
    @(posedge clock);
    #1;

    do_req(1, 4'd7, 5'd0, lat, s);
    check("lat_len0", lat, 1);
    check("sum_len0", s, 0);

    req_base[3:0] = 4'd0;
    req_len[4:0] = 5'd16;
    req_valid[0] = 1'b1;
    for (int n = 0; n < 50 && !req_ready[0]; n++) @(negedge clock);
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_rst_mem_rd_en", mem_rd_en, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_mem_rd_en", mem_rd_en, 0);
    check("midrst_mem_rd_addr", mem_rd_addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_sum", rsp_sum, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    do_req(0, 4'd2, 5'd3, lat, s);
    check("lat_after_rst", lat, 5);
    check("sum_after_rst", s, 9);

`ifdef CHECKSUM_SCHED_OVERFLOW_EN
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = 32'hFFFF_FFFF;
    do_req(0, 4'd0, 5'd2, lat, s);
    check("sum_ovf", s, 32'hFFFF_FFFE);
    do_req(1, 4'd2, 5'd1, lat, s);
    check("sum_no_ovf", s, 2);
`endif

    repeat (2) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/checksum_scheduler.md
Name: checksum_scheduler

Overview:
- Shares one synchronous-read word memory between NUM_REQ requesters.
- Each requester asks for the checksum (modular sum) of a contiguous address range.
- The block arbitrates round-robin, sequences the memory reads, accumulates the data and returns the result over a valid/ready response channel.
- Sits between the memory's read port and the client blocks that need range sums.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- ADDR_W, 4, memory address width; depth is 2^ADDR_W.
- DATA_W, 32, memory word and sum width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_base  in  NUM_REQ*ADDR_W  packed start addresses; requester i uses slice i.
- req_len  in  NUM_REQ*(ADDR_W+1)  packed word counts, 0..2^ADDR_W.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  clog2(NUM_REQ)  index of the served requester.
- rsp_sum  out  DATA_W  checksum result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, sum=0, all outputs 0.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - grant = first req_valid bit at or after rr_ptr (circular).
  - req_ready[grant] = 1, combinationally, only in IDLE.
  - On handshake: latch base, len and id; sum ← 0; rr_ptr ← grant+1 mod NUM_REQ.
  - Next state: ISSUE if len>0, RESP if len==0.
- ISSUE (len cycles):
  - mem_rd_en=1 and mem_rd_addr = base+k for k=0..len-1.
  - Address wraps modulo 2^ADDR_W.
  - Data returned in each cycle after a read is added to sum.
  - After the last issue: go to DRAIN.
- DRAIN (1 cycle): mem_rd_en=0; add the final mem_rd_data; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_sum held stable until rsp_ready.
  - On handshake: go to IDLE.
  - No new grant while in RESP.
- Latency, with the accept cycle as cycle 0:
  - len=L>0: rsp_valid first high in cycle L+2.
  - len=0: rsp_valid high in cycle 1 with rsp_sum=0.
- Arithmetic:
  - Sum is modulo 2^DATA_W; carries are discarded.
  - The issue counter is ADDR_W+1 bits so len=2^ADDR_W is legal.
- Request inputs are sampled only on the accept cycle; later changes are ignored.
- Reset mid-operation (ISSUE/DRAIN/RESP): everything returns immediately to reset values and the in-flight request is dropped.
- A requester that drops req_valid before its grant is simply skipped.

Optional Feature:
- Macro: CHECKSUM_SCHED_OVERFLOW_EN.
- When defined:
  - Adds output rsp_overflow (1 bit), a sticky flag set if any accumulation produced a carry out of DATA_W.
  - Cleared on accept; valid alongside rsp_valid; 0 on reset.
- When undefined: the port and its logic are absent; sums wrap silently.

Decomposition:
- Package checksum_sched_pkg:
  - state enum (IDLE, ISSUE, DRAIN, RESP);
  - default widths;
  - ID_W = clog2(NUM_REQ) helper.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant from req_valid and rr_ptr.
- Accumulator and FSM stay in the top module.

Test Plan:
- Memory preloaded mem[i]=i, depth 16; req0 base=0 len=16 → reads 0..15, rsp_sum=120 (0x78), rsp_id=0, rsp_valid first high in cycle 18.
- Wrap-around: req1 base=14 len=4 → addresses 14,15,0,1 and rsp_sum=30.
- Fairness: req0 and req1 both held valid with len=1 → responses in order id 0,1,0,1 with no starvation.
- Back-pressure: rsp_ready low 5 cycles in RESP → rsp_valid, rsp_id and rsp_sum stable, req_ready all 0, mem_rd_en 0.
- Edge and reset:
  - len=0 → rsp_sum=0 one cycle after accept.
  - reset_n pulsed low during ISSUE → outputs 0 immediately; a following base=2 len=3 request returns 9.
- Overflow (macro defined): mem[0]=mem[1]=0xFFFFFFFF, base=0 len=2 → rsp_sum=0xFFFFFFFE, rsp_overflow=1; next request without carry → rsp_overflow=0.
